// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequencing controller for the UART receiver.
// CLK runs at 8x the baud rate. Detects the start edge on RX_IN, generates the
// oversampling phase counter, tracks the bit index and drives the enables of
// the data sampler, deserializer and start/parity/stop checkers. Issues a
// one-cycle data_valid after every frame that passed all checks.
// Optional feature: define UART_RX_ERR_FLAGS_EN to add the sticky PAR_ERR_O /
// STP_ERR_O outputs, which report the error status of the last frame.
module uart_rx_ctrl #(
    parameter int Data_width = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic [2:0] edge_cnt,
    output logic       dat_samp_en,
    output logic       deser_en,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
`ifdef UART_RX_ERR_FLAGS_EN
    output logic       PAR_ERR_O,
    output logic       STP_ERR_O,
`endif
    output logic       data_valid
);

    localparam int cnt_w = $clog2(Data_width) + 1;
    localparam logic [cnt_w-1:0] last_bit = cnt_w'(Data_width - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t           state, state_nx;
    logic [2:0]       edge_nx;
    logic [cnt_w-1:0] bit_cnt, bit_cnt_nx;
    logic             par_en_q, par_en_nx;
    logic             err_q, err_nx;
    logic             dv_nx;
    logic             bit_end;
    logic             start_edge;

    // The last oversample phase of every bit outside IDLE.
    assign bit_end    = (edge_cnt == 3'd7) && (state != IDLE);
    // Falling line seen while idle: a new frame begins.
    assign start_edge = (state == IDLE) && !RX_IN;

    // State register and frame bookkeeping.
    // NOTE: the reset is asynchronous and active-low, so it sits in the
    // sensitivity list; every register here has a defined reset value.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            edge_cnt   <= 3'd0;
            bit_cnt    <= '0;
            par_en_q   <= 1'b0;
            err_q      <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // the values present before the clock edge.
            state      <= state_nx;
            edge_cnt   <= edge_nx;
            bit_cnt    <= bit_cnt_nx;
            par_en_q   <= par_en_nx;
            err_q      <= err_nx;
            data_valid <= dv_nx;
        end
    end

    // Next-state logic and Moore enables decoded from the current state.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        state_nx    = state;
        edge_nx     = (state == IDLE) ? 3'd0 : edge_cnt + 3'd1;
        bit_cnt_nx  = bit_cnt;
        par_en_nx   = par_en_q;
        err_nx      = err_q;
        dv_nx       = 1'b0;
        dat_samp_en = 1'b0;
        deser_en    = 1'b0;
        strt_chk_en = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;

        case (state)
            IDLE: begin
                if (start_edge) begin
                    state_nx  = START;
                    par_en_nx = PAR_EN;
                    err_nx    = 1'b0;
                end
            end
            START: begin
                dat_samp_en = 1'b1;
                strt_chk_en = 1'b1;
                if (bit_end) begin
                    if (strt_glitch) begin
                        state_nx = IDLE;
                    end else begin
                        state_nx   = DATA;
                        bit_cnt_nx = '0;
                    end
                end
            end
            DATA: begin
                dat_samp_en = 1'b1;
                deser_en    = 1'b1;
                if (bit_end) begin
                    if (bit_cnt == last_bit) begin
                        state_nx = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_nx = bit_cnt + cnt_w'(1);
                    end
                end
            end
            PARITY: begin
                dat_samp_en = 1'b1;
                par_chk_en  = 1'b1;
                if (bit_end) begin
                    err_nx   = par_err;
                    state_nx = STOP;
                end
            end
            STOP: begin
                dat_samp_en = 1'b1;
                stp_chk_en  = 1'b1;
                if (bit_end) begin
                    state_nx = IDLE;
                    dv_nx    = !stp_err && !err_q;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef UART_RX_ERR_FLAGS_EN
    // Sticky error flags: loaded when a frame completes, cleared at the next start edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            PAR_ERR_O <= 1'b0;
            STP_ERR_O <= 1'b0;
        end else if (start_edge) begin
            PAR_ERR_O <= 1'b0;
            STP_ERR_O <= 1'b0;
        end else if (state == STOP && bit_end) begin
            PAR_ERR_O <= err_q;
            STP_ERR_O <= stp_err;
        end
    end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: directed frames on RX_IN with a frame-timing model
// that derives the expected outputs from the elapsed time since the start edge.
module tb_uart_rx_ctrl;

    localparam int W = 8;
    // Cycle offset (from the start edge) of the parity bit's last phase.
    localparam int PAR_END = 8 * (W + 1) + 7;

    logic       CLK, RST, RX_IN, PAR_EN, strt_glitch, par_err, stp_err;
    logic [2:0] edge_cnt;
    logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid;
`ifdef UART_RX_ERR_FLAGS_EN
    logic       PAR_ERR_O, STP_ERR_O;
`endif

    uart_rx_ctrl #(.Data_width(W)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .PAR_EN      (PAR_EN),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .edge_cnt    (edge_cnt),
        .dat_samp_en (dat_samp_en),
        .deser_en    (deser_en),
        .strt_chk_en (strt_chk_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
`ifdef UART_RX_ERR_FLAGS_EN
        .PAR_ERR_O   (PAR_ERR_O),
        .STP_ERR_O   (STP_ERR_O),
`endif
        .data_valid  (data_valid)
    );

    int vectors = 0;
    int miscompares = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Free-running cycle count, bumped at each rising edge.
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- behavioural model ----------------
    // A frame is just "time since the start edge": bit index = t/8, phase = t%8.
    logic m_busy, m_par, m_err, m_dv;
    int   m_t;
`ifdef UART_RX_ERR_FLAGS_EN
    logic m_pf, m_sf;
`endif

    function automatic int last_t(input logic par);
        return 8 * (W + 2 + (par ? 1 : 0)) - 1;
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_busy <= 1'b0; m_t <= 0; m_par <= 1'b0; m_err <= 1'b0; m_dv <= 1'b0;
`ifdef UART_RX_ERR_FLAGS_EN
            m_pf <= 1'b0; m_sf <= 1'b0;
`endif
        end else begin
            m_dv <= 1'b0;
            if (!m_busy) begin
                if (!RX_IN) begin
                    m_busy <= 1'b1; m_t <= 0; m_par <= PAR_EN; m_err <= 1'b0;
`ifdef UART_RX_ERR_FLAGS_EN
                    m_pf <= 1'b0; m_sf <= 1'b0;
`endif
                end
            end else if (m_t == 7 && strt_glitch) begin
                m_busy <= 1'b0;
            end else if (m_t == last_t(m_par)) begin
                m_busy <= 1'b0;
                m_dv   <= !stp_err && !m_err;
`ifdef UART_RX_ERR_FLAGS_EN
                m_pf <= m_err; m_sf <= stp_err;
`endif
            end else begin
                m_t <= m_t + 1;
                if (m_par && m_t == PAR_END) m_err <= par_err;
            end
        end
    end

    // Packed view: {flags[1:0], edge[2:0], samp, deser, strt, par, stp, dv}.
    function automatic logic [10:0] exp_vec();
        int b;
        logic [1:0] fl;
        logic [2:0] e;
        b  = m_t / 8;
        e  = m_busy ? 3'(m_t % 8) : 3'd0;
        fl = 2'b00;
`ifdef UART_RX_ERR_FLAGS_EN
        fl = {m_pf, m_sf};
`endif
        return {fl, e, m_busy,
                m_busy && b >= 1 && b <= W,
                m_busy && b == 0,
                m_busy && m_par && b == W + 1,
                m_busy && b == W + 1 + (m_par ? 1 : 0),
                m_dv};
    endfunction

    function automatic logic [10:0] act_vec();
        logic [1:0] fl;
        fl = 2'b00;
`ifdef UART_RX_ERR_FLAGS_EN
        fl = {PAR_ERR_O, STP_ERR_O};
`endif
        return {fl, edge_cnt, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
                stp_chk_en, data_valid};
    endfunction

    // Per-cycle compare of every output against the model, away from the rising edge.
    always @(negedge CLK) begin
        vectors++;
        if (act_vec() !== exp_vec()) begin
            miscompares++;
            $display("FAIL cycle_compare @%0d: dut=%b model=%b", cyc, act_vec(), exp_vec());
        end
    end

    // ---------------- monitors ----------------
    int   shift_cnt = 0;
    int   strt_cycles = 0;
    int   par_cycles = 0;
    logic [7:0] rx_byte = 8'h00;
    int   dv_q[$];

    always @(negedge CLK) begin
        if (data_valid) dv_q.push_back(cyc);
        if (deser_en && edge_cnt == 3'd7) shift_cnt++;
        if (deser_en && edge_cnt == 3'd4) rx_byte = {RX_IN, rx_byte[7:1]};
        if (strt_chk_en) strt_cycles++;
        if (par_chk_en) par_cycles++;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic send_bits(input logic v, input int n);
        RX_IN = v;
        repeat (n) @(negedge CLK);
    endtask

    int start_cyc;

    // Serialize one frame from a negedge; stop_cycles > 8 adds idle line time.
    task automatic send_frame(input logic [7:0] d, input logic with_par,
                              input int stop_cycles, input logic flip_pe);
        logic [7:0] dd;
        dd = d;
        start_cyc = cyc + 1;
        send_bits(1'b0, 8);
        if (flip_pe) PAR_EN = !PAR_EN;
        for (int i = 0; i < 8; i++) send_bits(dd[i], 8);
        if (with_par) send_bits(1'b1, 8);
        send_bits(1'b1, stop_cycles);
    endtask

    int sh0, dv0, st0, pc0;
    task automatic mark();
        sh0 = shift_cnt; dv0 = dv_q.size(); st0 = strt_cycles; pc0 = par_cycles;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        logic [7:0] b5;
        RST = 1'b1; RX_IN = 1'b1; PAR_EN = 1'b0;
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        #1 RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_outputs", int'(act_vec()), 0);
        RST = 1'b1;
        repeat (4) @(negedge CLK);

        // 0xA5 without parity: 8 shifts, data_valid 80 cycles after the start edge.
        mark();
        send_frame(8'hA5, 1'b0, 16, 1'b0);
        check("t1_shifts", shift_cnt - sh0, 8);
        check("t1_dv_count", dv_q.size() - dv0, 1);
        if (dv_q.size() > dv0) check("t1_dv_latency", dv_q[dv0] - start_cyc, 80);
        check("t1_byte", int'(rx_byte), 'hA5);

        // Parity enabled with par_err; PAR_EN dropped mid-frame must not matter.
        PAR_EN = 1'b1; par_err = 1'b1;
        mark();
        send_frame(8'h96, 1'b1, 16, 1'b1);
        check("t2_shifts", shift_cnt - sh0, 8);
        check("t2_parity_cycles", par_cycles - pc0, 8);
        check("t2_dv_count", dv_q.size() - dv0, 0);
`ifdef UART_RX_ERR_FLAGS_EN
        check("t2_par_err_flag", int'(PAR_ERR_O), 1);
`endif
        PAR_EN = 1'b0; par_err = 1'b0;

        // Two-cycle low glitch rejected by the start checker.
        strt_glitch = 1'b1;
        mark();
        send_bits(1'b0, 2);
        send_bits(1'b1, 20);
        check("t3_start_cycles", strt_cycles - st0, 8);
        check("t3_shifts", shift_cnt - sh0, 0);
        check("t3_dv_count", dv_q.size() - dv0, 0);
        check("t3_back_idle", int'(dat_samp_en), 0);
        strt_glitch = 1'b0;
`ifdef UART_RX_ERR_FLAGS_EN
        check("t3_flags_cleared", int'({PAR_ERR_O, STP_ERR_O}), 0);
`endif

        // Back-to-back frames on an 11-bit-time line cadence.
        mark();
        send_frame(8'h3C, 1'b0, 16, 1'b0);
        check("t4_byte0", int'(rx_byte), 'h3C);
        send_frame(8'hC3, 1'b0, 16, 1'b0);
        check("t4_byte1", int'(rx_byte), 'hC3);
        check("t4_shifts", shift_cnt - sh0, 16);
        check("t4_dv_count", dv_q.size() - dv0, 2);
        if (dv_q.size() >= dv0 + 2) check("t4_dv_spacing", dv_q[dv0 + 1] - dv_q[dv0], 88);

        // Next start bit right after a single stop bit: picked up one cycle late.
        mark();
        send_frame(8'h11, 1'b0, 8, 1'b0);
        send_frame(8'hEE, 1'b0, 16, 1'b0);
        check("t4b_byte", int'(rx_byte), 'hEE);
        check("t4b_dv_count", dv_q.size() - dv0, 2);
        if (dv_q.size() >= dv0 + 2) check("t4b_dv_spacing", dv_q[dv0 + 1] - dv_q[dv0], 81);

        // Asynchronous reset during data bit 4, then a clean frame.
        mark();
        b5 = 8'h6B;
        send_bits(1'b0, 8);
        for (int i = 0; i < 4; i++) send_bits(b5[i], 8);
        send_bits(b5[4], 3);
        check("t5_in_data", int'(deser_en), 1);
        @(posedge CLK);
        #2 RST = 1'b0; RX_IN = 1'b1;
        #1 check("t5_async_reset", int'(act_vec()), 0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        send_bits(1'b1, 16);
        check("t5_no_dv", dv_q.size() - dv0, 0);
        mark();
        send_frame(8'h5A, 1'b0, 16, 1'b0);
        check("t5_byte", int'(rx_byte), 'h5A);
        check("t5_dv_count", dv_q.size() - dv0, 1);
        check("t5_shifts", shift_cnt - sh0, 8);

        // Stop-bit error suppresses data_valid.
        stp_err = 1'b1;
        mark();
        send_frame(8'h81, 1'b0, 16, 1'b0);
        check("t6_dv_count", dv_q.size() - dv0, 0);
`ifdef UART_RX_ERR_FLAGS_EN
        check("t6_stp_err_flag", int'(STP_ERR_O), 1);
        check("t6_par_err_flag", int'(PAR_ERR_O), 0);
`endif
        stp_err = 1'b0;

        repeat (4) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
